cr_axi4s_slv: RTL

CR_AXI4S_SLV -- requirements
Module: cr_axi4s_slv

---
 rtl/cr_axi4s_slv_pkg.sv | 29 ++
 rtl/cr_axi4s_skid.sv | 53 +++++
 rtl/cr_axi4s_slv.sv | 71 +++++++
 3 files changed

// File: rtl/cr_axi4s_slv_pkg.sv
// Shared AXI4-Stream datapath types and widths (cr_structs / axi_reg_slice_defs) plus skid occupancy encoding.
// Optional statistics in cr_axi4s_slv are enabled by defining CR_AXI4S_SLV_STATS_EN.
package cr_axi4s_slv_pkg;

    localparam int unsigned AXI_S_DP_DWIDTH    = 64;
    localparam int unsigned AXI_S_TID_WIDTH    = 8;
    localparam int unsigned AXI_S_USER_WIDTH   = 8;
    localparam int unsigned AXI_S_TSTRB_WIDTH  = AXI_S_DP_DWIDTH / 8;

    typedef struct packed {
        logic                          tvalid;
        logic                          tlast;
        logic [AXI_S_TID_WIDTH-1:0]    tid;
        logic [AXI_S_TSTRB_WIDTH-1:0]  tstrb;
        logic [AXI_S_USER_WIDTH-1:0]   tuser;
        logic [AXI_S_DP_DWIDTH-1:0]    tdata;
    } axi4s_dp_bus_t;

    typedef struct packed {
        logic tready;
    } axi4s_dp_rdy_t;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } skid_occ_e;

endpackage

// File: rtl/cr_axi4s_skid.sv
// Two-entry skid buffer: head is always the oldest beat, ready is registered from next occupancy.
module cr_axi4s_skid
    import cr_axi4s_slv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  axi4s_dp_bus_t push_data,
    input  logic          pop,
    output axi4s_dp_bus_t head,
    output skid_occ_e     occ,
    output logic          ready
);

    axi4s_dp_bus_t slot1;
    skid_occ_e     occ_next;

    always_comb begin
        occ_next = occ;
        case (occ)
            OCC_EMPTY: if (push) occ_next = OCC_ONE;
            OCC_ONE: begin
                if (push && !pop)      occ_next = OCC_TWO;
                else if (pop && !push) occ_next = OCC_EMPTY;
            end
            OCC_TWO:   if (pop) occ_next = OCC_ONE;
            default:   occ_next = OCC_EMPTY;
        endcase
    end

    // ready is low whenever occupancy is TWO, so push never coincides with a full buffer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ   <= OCC_EMPTY;
            ready <= 1'b0;
            head  <= '0;
            slot1 <= '0;
        end else begin
            occ   <= occ_next;
            ready <= (occ_next != OCC_TWO);
            case (occ)
                OCC_EMPTY: if (push) head <= push_data;
                OCC_ONE: begin
                    if (push && pop) head  <= push_data;
                    else if (push)   slot1 <= push_data;
                end
                OCC_TWO:   if (pop) head <= slot1;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/cr_axi4s_slv.sv
// AXI4-Stream slave into a downstream FIFO via a registered 2-entry skid buffer.
// Define CR_AXI4S_SLV_STATS_EN to build the saturating beat/frame counters.
module cr_axi4s_slv
    import cr_axi4s_slv_pkg::*;
#(
    parameter int unsigned STAT_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  axi4s_dp_bus_t         axi4s_ib_in,
    output axi4s_dp_rdy_t         axi4s_ib_out,
    output logic                  axi4s_slv_wr,
    output axi4s_dp_bus_t         axi4s_slv_out,
    input  logic                  axi4s_out_full,
    output logic [STAT_WIDTH-1:0] stat_beats,
    output logic [STAT_WIDTH-1:0] stat_frames
);

    logic          ready;
    logic          push;
    logic          pop;
    skid_occ_e     occ;
    axi4s_dp_bus_t head;

    assign push = axi4s_ib_in.tvalid & ready;
    assign pop  = (occ != OCC_EMPTY) & ~axi4s_out_full;

    cr_axi4s_skid u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (axi4s_ib_in),
        .pop       (pop),
        .head      (head),
        .occ       (occ),
        .ready     (ready)
    );

    assign axi4s_ib_out.tready = ready;
    assign axi4s_slv_wr        = pop;

    // Stored beats always carry tvalid=1, so gating with pop gives tvalid == axi4s_slv_wr
    always_comb begin
        axi4s_slv_out        = head;
        axi4s_slv_out.tvalid = head.tvalid & pop;
    end

`ifdef CR_AXI4S_SLV_STATS_EN
    logic [STAT_WIDTH-1:0] beats_q;
    logic [STAT_WIDTH-1:0] frames_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_q  <= '0;
            frames_q <= '0;
        end else if (push) begin
            if (beats_q != '1)
                beats_q <= beats_q + STAT_WIDTH'(1);
            if (axi4s_ib_in.tlast && (frames_q != '1))
                frames_q <= frames_q + STAT_WIDTH'(1);
        end
    end

    assign stat_beats  = beats_q;
    assign stat_frames = frames_q;
`else
    assign stat_beats  = '0;
    assign stat_frames = '0;
`endif

endmodule
